// File: rtl/alarma_ctrl.sv
// Alarm controller: 2-of-3 sensor vote, debounce, latched alarm with acknowledge, square-wave siren.
// Optional entry log (alarm_count, last_cause) is built only when ALARM_LOG_EN is defined.
module alarma_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int SIREN_HALF = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       arm,
  input  logic       ack,
  output logic       alarm_on,
  output logic       siren,
  output logic [1:0] state,
  output logic [7:0] alarm_count,
  output logic [2:0] last_cause
);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    PENDING  = 2'b10,
    ALARM    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIR_LAST = CNT_W'(SIREN_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] deb_cnt_nx;
  logic [CNT_W-1:0] sir_cnt;
  logic             trigger;
  logic             enter_alarm;
  logic             stay_alarm;

  // Majority vote: at least two of the three sensors must agree.
  assign trigger     = (a & b) | (a & c) | (b & c);
  assign enter_alarm = (nxt_state == ALARM) && (cur_state != ALARM);
  assign stay_alarm  = (nxt_state == ALARM) && (cur_state == ALARM);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= DISARMED;
      deb_cnt   <= '0;
    end else begin
      cur_state <= nxt_state;
      deb_cnt   <= deb_cnt_nx;
    end
  end

  // NOTE: defaults assigned first so every path drives every output and no latch is inferred.
  always_comb begin
    nxt_state  = cur_state;
    deb_cnt_nx = deb_cnt;
    case (cur_state)
      DISARMED: begin
        deb_cnt_nx = '0;
        if (arm) nxt_state = ARMED;
      end
      ARMED: begin
        deb_cnt_nx = '0;
        if (!arm) begin
          nxt_state = DISARMED;
        end else if (trigger) begin
          if (DEB_CYCLES == 1) begin
            nxt_state = ALARM;
          end else begin
            nxt_state  = PENDING;
            deb_cnt_nx = CNT_ONE;
          end
        end
      end
      PENDING: begin
        if (!arm) begin
          nxt_state  = DISARMED;
          deb_cnt_nx = '0;
        end else if (!trigger) begin
          nxt_state  = ARMED;
          deb_cnt_nx = '0;
        end else if (deb_cnt == DEB_LAST) begin
          nxt_state  = ALARM;
          deb_cnt_nx = '0;
        end else begin
          deb_cnt_nx = deb_cnt + CNT_ONE;
        end
      end
      ALARM: begin
        deb_cnt_nx = '0;
        // Acknowledge only clears once the sensors have gone quiet.
        if (ack && !trigger) nxt_state = arm ? ARMED : DISARMED;
      end
      default: begin
        nxt_state  = DISARMED;
        deb_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      siren   <= 1'b0;
      sir_cnt <= '0;
    end else if (enter_alarm) begin
      siren   <= 1'b1;
      sir_cnt <= '0;
    end else if (stay_alarm) begin
      if (sir_cnt == SIR_LAST) begin
        siren   <= ~siren;
        sir_cnt <= '0;
      end else begin
        sir_cnt <= sir_cnt + CNT_ONE;
      end
    end else begin
      siren   <= 1'b0;
      sir_cnt <= '0;
    end
  end

`ifdef ALARM_LOG_EN
  logic [7:0] cnt_q;
  logic [2:0] cause_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      cause_q <= '0;
    end else if (enter_alarm) begin
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      cause_q <= {a, b, c};
    end
  end

  assign alarm_count = cnt_q;
  assign last_cause  = cause_q;
`else
  assign alarm_count = 8'd0;
  assign last_cause  = 3'b000;
`endif

  assign state    = cur_state;
  assign alarm_on = (cur_state == ALARM);

endmodule

// File: tb/tb_alarma_ctrl.sv
// Directed bench for alarma_ctrl: vector table for the FSM walk plus hand sequences for
// siren timing, asynchronous reset mid-alarm and alarm_count saturation.
module tb_alarma_ctrl;

`ifdef ALARM_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       a, b, c, arm, ack;
  logic       alarm_on, siren;
  logic [1:0] state;
  logic [7:0] alarm_count;
  logic [2:0] last_cause;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [2:0] exp_cause = 3'b000;

  alarma_ctrl #(.DEB_CYCLES(4), .SIREN_HALF(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .arm(arm), .ack(ack),
    .alarm_on(alarm_on), .siren(siren), .state(state),
    .alarm_count(alarm_count), .last_cause(last_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] abc;
    logic       arm;
    logic       ack;
    logic [1:0] st;
    logic       sir;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] abc, input logic arm_v, input logic ack_v);
    {a, b, c} = abc;
    arm = arm_v;
    ack = ack_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_entry(input logic [2:0] cause);
    if (exp_cnt < 255) exp_cnt++;
    exp_cause = cause;
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, {24'd0, alarm_count}, LOG_EN ? exp_cnt : 0);
    check({name, "_cause"}, {29'd0, last_cause}, LOG_EN ? {29'd0, exp_cause} : 0);
  endtask

  // From ARMED: hold a trigger pattern for DEB_CYCLES edges to reach ALARM.
  task automatic go_alarm(input logic [2:0] cause);
    drive(cause, 1'b1, 1'b0);
    repeat (4) tick();
    note_entry(cause);
  endtask

  initial begin
    logic [2:0] causes[4];
    causes[0] = 3'b011; causes[1] = 3'b101; causes[2] = 3'b110; causes[3] = 3'b111;

    vecs[0]  = '{3'b000, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{3'b000, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[2]  = '{3'b110, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[3]  = '{3'b110, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[4]  = '{3'b110, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[5]  = '{3'b110, 1'b1, 1'b0, 2'b11, 1'b1};
    vecs[6]  = '{3'b111, 1'b1, 1'b1, 2'b11, 1'b1};
    vecs[7]  = '{3'b000, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[8]  = '{3'b011, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[9]  = '{3'b011, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[10] = '{3'b011, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[11] = '{3'b001, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[12] = '{3'b100, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[13] = '{3'b101, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[14] = '{3'b101, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[15] = '{3'b111, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[16] = '{3'b111, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[17] = '{3'b111, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[18] = '{3'b000, 1'b1, 1'b0, 2'b01, 1'b0};

    reset = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    repeat (2) tick();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_alarm_on", {31'd0, alarm_on}, 32'd0);
    check("rst_siren", {31'd0, siren}, 32'd0);
    check_log("rst");
    #3 reset = 1'b0;

    // FSM walk: latency, 2-of-3 decode, debounce abort, ack while triggered, disarm paths.
    foreach (vecs[i]) begin
      drive(vecs[i].abc, vecs[i].arm, vecs[i].ack);
      tick();
      check($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].st});
      check($sformatf("vec%0d_alarm_on", i), {31'd0, alarm_on}, {31'd0, (vecs[i].st == 2'b11)});
      check($sformatf("vec%0d_siren", i), {31'd0, siren}, {31'd0, vecs[i].sir});
      if (i == 5) note_entry(3'b110);
    end
    check_log("table");

    // Siren: 8 clocks high, 8 low, repeating, starting on the entry edge.
    go_alarm(3'b111);
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      check($sformatf("siren_k%0d", k), {31'd0, siren}, {31'd0, ((k / 8) % 2 == 0)});
      check($sformatf("siren_state_k%0d", k), {30'd0, state}, 32'd3);
    end
    drive(3'b000, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      check("disarm_no_ack_state", {30'd0, state}, 32'd3);
    end
    drive(3'b000, 1'b0, 1'b1);
    tick();
    check("ack_disarm_state", {30'd0, state}, 32'd0);
    check("ack_disarm_siren", {31'd0, siren}, 32'd0);
    check_log("siren_seq");

    // Asynchronous reset in the middle of a clock period while the siren is on.
    drive(3'b000, 1'b1, 1'b0);
    tick();
    go_alarm(3'b101);
    check("pre_rst_state", {30'd0, state}, 32'd3);
    check("pre_rst_siren", {31'd0, siren}, 32'd1);
    check_log("pre_rst");
    #2 reset = 1'b1;
    #1;
    exp_cnt = 0;
    exp_cause = 3'b000;
    check("async_rst_state", {30'd0, state}, 32'd0);
    check("async_rst_alarm_on", {31'd0, alarm_on}, 32'd0);
    check("async_rst_siren", {31'd0, siren}, 32'd0);
    check_log("async_rst");
    #3 reset = 1'b0;
    drive(3'b111, 1'b0, 1'b0);
    tick();
    check("post_rst_state", {30'd0, state}, 32'd0);

    // 256 alarm/ack cycles: the entry count saturates at 255.
    drive(3'b000, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 256; i++) begin
      go_alarm(causes[i % 4]);
      check("sat_alarm_state", {30'd0, state}, 32'd3);
      if (i == 254 || i == 255) check_log($sformatf("sat_%0d", i + 1));
      drive(3'b000, 1'b1, 1'b1);
      tick();
      check("sat_ack_state", {30'd0, state}, 32'd1);
    end
    check("sat_final_count", {24'd0, alarm_count}, LOG_EN ? 32'd255 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
